mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one unified memory port between the CPU instruction-fetch port and the CPU data port.
- Replaces the separate program_memory/data_memory pair with a single backing memory behind a req/ack handshake.
- Priority is fixed with the data port first, plus a starvation guard for fetch and a watchdog timeout that returns an error instead of hanging the CPU.
- Sits between cpu and the unified memory model.

Parameters:
- XLEN, 32: data width (`XLEN).
- XADDR, 32: address width (`XADDR).
- STREAK_MAX, 4: max consecutive data grants while a fetch is pending.
- TIMEOUT, 255: cycles to wait for i_mem_ack before abort; 0 disables the watchdog.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_inst_req  in  1  fetch request, held until o_inst_ack.
- i_inst_addr  in  XADDR  fetch address.
- o_inst_ack  out  1  one-cycle completion pulse.
- o_inst_data  out  XLEN  instruction word, valid with o_inst_ack.
- o_inst_err  out  1  timeout flag, valid with o_inst_ack.
- i_data_req  in  1  load/store request, held until o_data_ack.
- i_data_addr  in  XADDR  data address.
- i_data_wdata  in  XLEN  store data.
- i_data_funct3  in  3  access size/sign.
- i_data_rw  in  1  0 = read, 1 = write.
- o_data_ack  out  1  one-cycle completion pulse.
- o_data_rdata  out  XLEN  load data, valid with o_data_ack.
- o_data_err  out  1  timeout flag, valid with o_data_ack.
- o_mem_req  out  1  memory request, held until ack or timeout.
- o_mem_addr  out  XADDR  memory address.
- o_mem_wdata  out  XLEN  memory write data.
- o_mem_funct3  out  3  memory access size/sign.
- o_mem_rw  out  1  memory read/write.
- i_mem_ack  in  1  one-cycle memory ack; read data valid in the same cycle.
- i_mem_rdata  in  XLEN  memory read data.

Behaviour:
- Reset (async, i_rst_n=0):
  - State IDLE; streak and timeout counters cleared.
  - All outputs 0.
  - Reset asserted mid-transaction abandons it; no ack is issued afterwards.
- States: IDLE, WAIT_ACK, RESP. All outputs are registered.
- IDLE, grant selection:
  - Data only pending -> grant data.
  - Inst only pending -> grant inst.
  - Both pending -> grant data unless streak==STREAK_MAX, then grant inst.
  - Neither pending -> stay IDLE.
- On grant (edge ending cycle N):
  - Latch addr, wdata, funct3 and rw onto o_mem_* and set o_mem_req=1 from cycle N+1. Go to WAIT_ACK.
  - A fetch drives o_mem_funct3=3'b010, o_mem_rw=0, o_mem_wdata=0.
- Streak counter:
  - Increments on a data grant made while i_inst_req=1.
  - Clears on an inst grant, or on a data grant with i_inst_req=0.
  - Saturates at STREAK_MAX.
- WAIT_ACK, i_mem_ack=1 in cycle k:
  - At k+1: o_mem_req=0; the granted port's ack=1, its data = captured i_mem_rdata (0 for writes), err=0. Go to RESP.
- WAIT_ACK timeout:
  - The counter increments every WAIT_ACK cycle.
  - When it reaches TIMEOUT without ack: o_mem_req=0, granted port's ack=1, err=1, data=0. Go to RESP.
  - An ack arriving in the same cycle as the timeout wins (normal completion).
- RESP:
  - Lasts one cycle; ack/err drop at the next edge. Go to IDLE.
  - i_mem_ack and both request inputs are ignored in RESP.
- Requester rules:
  - Deassert req no later than the cycle after its ack.
  - Keep addr/data stable while req=1.
- Memory rule: i_mem_ack high for exactly one cycle per o_mem_req assertion. Acks seen in IDLE or RESP are ignored.
- Back-to-back throughput: minimum 3 cycles per transaction (issue, ack, resp) plus memory latency.
- o_inst_data/o_data_rdata hold their last value between acks.

Decomposition:
- header.vh (shared) gains:
  - ARB_IDLE/ARB_WAIT_ACK/ARB_RESP state encodings (2 bits).
  - FUNCT3_LW = 3'b010.
  - Existing `XLEN/`XADDR are reused.
- One sub-module, arb_priority_select (combinational):
  - Inputs: inst_req, data_req, streak_full.
  - Outputs: grant_valid, grant_is_data.
  - Instantiated once. Counters and FSM stay in mem_arbiter.

Test Plan:
1. Fetch only: i_inst_req=1, addr 0x0000_0010; memory acks 2 cycles after o_mem_req with 0x0000_0013 -> o_mem_req high for 3 cycles with funct3=010, rw=0; o_inst_ack single pulse, o_inst_data=0x0000_0013, o_inst_err=0.
2. Simultaneous request: inst 0x04 and data read 0x100 raised together -> first o_mem_addr=0x100; inst serviced next; each ack exactly once to the correct port.
3. Starvation guard: data_req held continuously with fresh addresses, inst_req held, STREAK_MAX=4 -> grant sequence data×4, inst, data…; inst latency bounded.
4. Store: data_rw=1, addr 0x200, wdata 0xDEAD_BEEF, funct3=000 -> o_mem_wdata/funct3/rw match; o_data_ack with rdata=0, err=0.
5. Timeout: TIMEOUT=8, memory never acks -> o_mem_req drops after 8 WAIT_ACK cycles; o_data_ack=1, o_data_err=1, rdata=0; the next request is serviced normally.
6. Reset mid-op: assert i_rst_n=0 during WAIT_ACK -> all outputs 0 immediately (async); a late i_mem_ack after release produces no ack pulse.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and constants for the unified memory arbiter
//
// Contents:
//   arb_state_t  arbiter FSM states (IDLE, WAIT_ACK, RESP), 2-bit encoding
//   FUNCT3_LW    access size driven for instruction fetches (32-bit word)
//   cnt_width()  bits needed to hold a counter value 0..maxv (minimum 1)
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_WAIT_ACK = 2'd1,
    ARB_RESP     = 2'd2
  } arb_state_t;

  localparam logic [2:0] FUNCT3_LW = 3'b010;

  function automatic int cnt_width(input int maxv);
    int w;
    w = 1;
    while ((1 << w) <= maxv) w++;
    return w;
  endfunction

endpackage

// File: rtl/mem_arbiter_priority_select.sv
// rtl/mem_arbiter_priority_select.sv - fixed data-first grant selection with fetch starvation override
//
// Ports:
//   inst_req       fetch port has a pending request
//   data_req       data port has a pending request
//   streak_full    data has won STREAK_MAX grants in a row while a fetch waited
//   grant_valid    some port can be granted this cycle
//   grant_is_data  the grant goes to the data port (meaningful with grant_valid)
module arb_priority_select (
  input  logic inst_req,
  input  logic data_req,
  input  logic streak_full,
  output logic grant_valid,
  output logic grant_is_data
);

  assign grant_valid   = inst_req | data_req;
  // Data wins unless a waiting fetch has already been passed over too often.
  assign grant_is_data = data_req & ~(inst_req & streak_full);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory port between CPU fetch and data ports with a watchdog
//
// Ports:
//   i_clk, i_rst_n                      clock (rising edge), async active-low reset
//   i_inst_req/i_inst_addr              fetch request, held until o_inst_ack
//   o_inst_ack/o_inst_data/o_inst_err   one-cycle fetch completion, word, timeout flag
//   i_data_req/i_data_addr/i_data_wdata
//   i_data_funct3/i_data_rw             load/store request, held until o_data_ack
//   o_data_ack/o_data_rdata/o_data_err  one-cycle data completion, load word, timeout flag
//   o_mem_req/o_mem_addr/o_mem_wdata
//   o_mem_funct3/o_mem_rw               unified memory request, held until ack or timeout
//   i_mem_ack/i_mem_rdata               one-cycle memory ack with read data
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int XADDR      = 32,
  parameter int STREAK_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inst_req,
  input  logic [XADDR-1:0] i_inst_addr,
  output logic             o_inst_ack,
  output logic [XLEN-1:0]  o_inst_data,
  output logic             o_inst_err,
  input  logic             i_data_req,
  input  logic [XADDR-1:0] i_data_addr,
  input  logic [XLEN-1:0]  i_data_wdata,
  input  logic [2:0]       i_data_funct3,
  input  logic             i_data_rw,
  output logic             o_data_ack,
  output logic [XLEN-1:0]  o_data_rdata,
  output logic             o_data_err,
  output logic             o_mem_req,
  output logic [XADDR-1:0] o_mem_addr,
  output logic [XLEN-1:0]  o_mem_wdata,
  output logic [2:0]       o_mem_funct3,
  output logic             o_mem_rw,
  input  logic             i_mem_ack,
  input  logic [XLEN-1:0]  i_mem_rdata
);

  localparam int SW = cnt_width(STREAK_MAX);
  localparam int TW = cnt_width(TIMEOUT);
  localparam logic [SW-1:0] STREAK_CAP = SW'(STREAK_MAX);
  // The watchdog fires on the edge that would take the counter to TIMEOUT.
  localparam logic [TW-1:0] TMO_LAST   = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit            TMO_EN     = (TIMEOUT > 0);

  arb_state_t       state_q, state_d;
  logic             gnt_data_q, gnt_data_d;
  logic [SW-1:0]    streak_q, streak_d;
  logic [TW-1:0]    timer_q, timer_d;

  logic             mem_req_q, mem_req_d;
  logic [XADDR-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]  mem_wdata_q, mem_wdata_d;
  logic [2:0]       mem_funct3_q, mem_funct3_d;
  logic             mem_rw_q, mem_rw_d;

  logic             inst_ack_q, inst_ack_d;
  logic [XLEN-1:0]  inst_data_q, inst_data_d;
  logic             inst_err_q, inst_err_d;
  logic             data_ack_q, data_ack_d;
  logic [XLEN-1:0]  data_rdata_q, data_rdata_d;
  logic             data_err_q, data_err_d;

  logic             grant_valid;
  logic             grant_is_data;
  logic             streak_full;
  logic             timed_out;
  logic [XLEN-1:0]  resp_word;

  assign streak_full = (streak_q == STREAK_CAP);

  arb_priority_select u_priority_select (
    .inst_req      (i_inst_req),
    .data_req      (i_data_req),
    .streak_full   (streak_full),
    .grant_valid   (grant_valid),
    .grant_is_data (grant_is_data)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ARB_IDLE;
      gnt_data_q   <= 1'b0;
      streak_q     <= '0;
      timer_q      <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_funct3_q <= '0;
      mem_rw_q     <= 1'b0;
      inst_ack_q   <= 1'b0;
      inst_data_q  <= '0;
      inst_err_q   <= 1'b0;
      data_ack_q   <= 1'b0;
      data_rdata_q <= '0;
      data_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_data_q   <= gnt_data_d;
      streak_q     <= streak_d;
      timer_q      <= timer_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_funct3_q <= mem_funct3_d;
      mem_rw_q     <= mem_rw_d;
      inst_ack_q   <= inst_ack_d;
      inst_data_q  <= inst_data_d;
      inst_err_q   <= inst_err_d;
      data_ack_q   <= data_ack_d;
      data_rdata_q <= data_rdata_d;
      data_err_q   <= data_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    gnt_data_d   = gnt_data_q;
    streak_d     = streak_q;
    timer_d      = timer_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_funct3_d = mem_funct3_q;
    mem_rw_d     = mem_rw_q;
    // Acks and error flags are single-cycle pulses; read data holds.
    inst_ack_d   = 1'b0;
    inst_err_d   = 1'b0;
    inst_data_d  = inst_data_q;
    data_ack_d   = 1'b0;
    data_err_d   = 1'b0;
    data_rdata_d = data_rdata_q;
    timed_out    = 1'b0;
    resp_word    = '0;

    unique case (state_q)
      ARB_IDLE: begin
        if (grant_valid) begin
          state_d    = ARB_WAIT_ACK;
          gnt_data_d = grant_is_data;
          timer_d    = '0;
          mem_req_d  = 1'b1;
          if (grant_is_data) begin
            mem_addr_d   = i_data_addr;
            mem_wdata_d  = i_data_wdata;
            mem_funct3_d = i_data_funct3;
            mem_rw_d     = i_data_rw;
            // Only count data wins that actually made a fetch wait.
            if (!i_inst_req)       streak_d = '0;
            else if (!streak_full) streak_d = streak_q + 1'b1;
          end else begin
            mem_addr_d   = i_inst_addr;
            mem_wdata_d  = '0;
            mem_funct3_d = FUNCT3_LW;
            mem_rw_d     = 1'b0;
            streak_d     = '0;
          end
        end
      end

      ARB_WAIT_ACK: begin
        timer_d = timer_q + 1'b1;
        // A real ack in the final watchdog cycle still completes normally.
        if (i_mem_ack || (TMO_EN && (timer_q == TMO_LAST))) begin
          timed_out = ~i_mem_ack;
          resp_word = (timed_out || mem_rw_q) ? '0 : i_mem_rdata;
          state_d   = ARB_RESP;
          mem_req_d = 1'b0;
          timer_d   = '0;
          if (gnt_data_q) begin
            data_ack_d   = 1'b1;
            data_rdata_d = resp_word;
            data_err_d   = timed_out;
          end else begin
            inst_ack_d   = 1'b1;
            inst_data_d  = resp_word;
            inst_err_d   = timed_out;
          end
        end
      end

      ARB_RESP: begin
        state_d = ARB_IDLE;
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  assign o_mem_req    = mem_req_q;
  assign o_mem_addr   = mem_addr_q;
  assign o_mem_wdata  = mem_wdata_q;
  assign o_mem_funct3 = mem_funct3_q;
  assign o_mem_rw     = mem_rw_q;
  assign o_inst_ack   = inst_ack_q;
  assign o_inst_data  = inst_data_q;
  assign o_inst_err   = inst_err_q;
  assign o_data_ack   = data_ack_q;
  assign o_data_rdata = data_rdata_q;
  assign o_data_err   = data_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter against a transaction reference model
module tb_mem_arbiter;

  localparam int SMAX = 4;
  localparam int TMO  = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_inst_req;
  logic [31:0] i_inst_addr;
  logic        o_inst_ack;
  logic [31:0] o_inst_data;
  logic        o_inst_err;
  logic        i_data_req;
  logic [31:0] i_data_addr;
  logic [31:0] i_data_wdata;
  logic [2:0]  i_data_funct3;
  logic        i_data_rw;
  logic        o_data_ack;
  logic [31:0] o_data_rdata;
  logic        o_data_err;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [2:0]  o_mem_funct3;
  logic        o_mem_rw;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(
    .XLEN(32), .XADDR(32), .STREAK_MAX(SMAX), .TIMEOUT(TMO)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_inst_req(i_inst_req), .i_inst_addr(i_inst_addr),
    .o_inst_ack(o_inst_ack), .o_inst_data(o_inst_data), .o_inst_err(o_inst_err),
    .i_data_req(i_data_req), .i_data_addr(i_data_addr), .i_data_wdata(i_data_wdata),
    .i_data_funct3(i_data_funct3), .i_data_rw(i_data_rw),
    .o_data_ack(o_data_ack), .o_data_rdata(o_data_rdata), .o_data_err(o_data_err),
    .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_mem_funct3(o_mem_funct3), .o_mem_rw(o_mem_rw),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic        rw;
  } dreq_t;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] inst_q[$];
  dreq_t       data_q[$];
  logic [31:0] mem_log[$];

  int inst_acks, data_acks, mem_hi, pushes;
  bit seen_req;
  int mem_age, cur_lat, lat_mode;
  bit gen_en, stray_en, force_stray;

  logic        p_inst_req, p_data_req, p_data_rw, p_mem_ack;
  logic [31:0] p_inst_addr, p_data_addr, p_data_wdata, p_mem_rdata;
  logic [2:0]  p_data_f3;

  int          m_ph, m_wait, m_streak;
  bit          m_is_data;
  logic        e_mem_req, e_mem_rw, e_inst_ack, e_inst_err, e_data_ack, e_data_err;
  logic [31:0] e_mem_addr, e_mem_wdata, e_inst_data, e_data_rdata;
  logic [2:0]  e_mem_f3;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'h0000_0013;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_mem_req"}, o_mem_req, 0);
    chk({tag, "_mem_addr"}, o_mem_addr, 0);
    chk({tag, "_mem_wdata"}, o_mem_wdata, 0);
    chk({tag, "_mem_f3"}, o_mem_funct3, 0);
    chk({tag, "_mem_rw"}, o_mem_rw, 0);
    chk({tag, "_inst_ack"}, o_inst_ack, 0);
    chk({tag, "_inst_data"}, o_inst_data, 0);
    chk({tag, "_inst_err"}, o_inst_err, 0);
    chk({tag, "_data_ack"}, o_data_ack, 0);
    chk({tag, "_data_rdata"}, o_data_rdata, 0);
    chk({tag, "_data_err"}, o_data_err, 0);
  endtask

  task automatic model_reset();
    m_ph = 0; m_wait = 0; m_streak = 0; m_is_data = 0;
    e_mem_req = 0; e_mem_rw = 0; e_mem_addr = 0; e_mem_wdata = 0; e_mem_f3 = 0;
    e_inst_ack = 0; e_inst_err = 0; e_inst_data = 0;
    e_data_ack = 0; e_data_err = 0; e_data_rdata = 0;
    p_inst_req = 0; p_data_req = 0; p_data_rw = 0; p_mem_ack = 0;
    p_inst_addr = 0; p_data_addr = 0; p_data_wdata = 0; p_mem_rdata = 0; p_data_f3 = 0;
  endtask

  // Arbiter phases: 0 free, 1 memory request outstanding, 2 response cycle.
  task automatic model_advance();
    bit          to;
    logic [31:0] word;
    e_inst_ack = 0; e_data_ack = 0; e_inst_err = 0; e_data_err = 0;
    if (m_ph == 0) begin
      if (p_data_req && !(p_inst_req && m_streak >= SMAX)) begin
        m_is_data = 1;
        e_mem_addr = p_data_addr; e_mem_wdata = p_data_wdata;
        e_mem_f3 = p_data_f3; e_mem_rw = p_data_rw;
        m_streak = p_inst_req ? m_streak + 1 : 0;
        m_ph = 1;
      end else if (p_inst_req) begin
        m_is_data = 0;
        e_mem_addr = p_inst_addr; e_mem_wdata = 0; e_mem_f3 = 3'b010; e_mem_rw = 0;
        m_streak = 0;
        m_ph = 1;
      end
      if (m_ph == 1) begin
        e_mem_req = 1;
        m_wait = 0;
      end
    end else if (m_ph == 1) begin
      m_wait++;
      if (p_mem_ack || m_wait == TMO) begin
        to = !p_mem_ack;
        word = (to || e_mem_rw) ? 32'h0 : p_mem_rdata;
        e_mem_req = 0;
        m_ph = 2;
        if (m_is_data) begin
          e_data_ack = 1; e_data_err = to; e_data_rdata = word;
        end else begin
          e_inst_ack = 1; e_inst_err = to; e_inst_data = word;
        end
      end
    end else begin
      m_ph = 0;
    end
  endtask

  function automatic int pick_lat();
    if (lat_mode >= -1) return lat_mode;
    if ($urandom_range(0, 19) == 0) return -1;
    return int'($urandom_range(0, 3));
  endfunction

  task automatic step();
    logic        ack;
    logic [31:0] rd;
    dreq_t       d;
    @(posedge clk);
    #1;
    model_advance();
    chk("mem_req", o_mem_req, e_mem_req);
    if (e_mem_req) begin
      chk("mem_addr", o_mem_addr, e_mem_addr);
      chk("mem_wdata", o_mem_wdata, e_mem_wdata);
      chk("mem_funct3", o_mem_funct3, e_mem_f3);
      chk("mem_rw", o_mem_rw, e_mem_rw);
    end
    chk("inst_ack", o_inst_ack, e_inst_ack);
    chk("inst_err", o_inst_err, e_inst_err);
    chk("inst_data", o_inst_data, e_inst_data);
    chk("data_ack", o_data_ack, e_data_ack);
    chk("data_err", o_data_err, e_data_err);
    chk("data_rdata", o_data_rdata, e_data_rdata);

    if (o_mem_req && !seen_req) mem_log.push_back(o_mem_addr);
    seen_req = o_mem_req;
    if (o_mem_req) mem_hi++;
    if (o_inst_ack) begin
      inst_acks++;
      if (inst_q.size() > 0) void'(inst_q.pop_front());
    end
    if (o_data_ack) begin
      data_acks++;
      if (data_q.size() > 0) void'(data_q.pop_front());
    end

    if (gen_en) begin
      if (inst_q.size() == 0 && $urandom_range(0, 2) == 0) begin
        inst_q.push_back($urandom & 32'hFFFF_FFFC);
        pushes++;
      end
      if (data_q.size() == 0 && $urandom_range(0, 1) == 0) begin
        d.addr = $urandom; d.wdata = $urandom;
        d.f3 = 3'($urandom_range(0, 7)); d.rw = 1'($urandom_range(0, 1));
        data_q.push_back(d);
        pushes++;
      end
    end

    i_inst_req  = (inst_q.size() != 0);
    i_inst_addr = i_inst_req ? inst_q[0] : $urandom;
    i_data_req  = (data_q.size() != 0);
    if (i_data_req) begin
      d = data_q[0];
    end else begin
      d.addr = $urandom; d.wdata = $urandom; d.f3 = 3'($urandom_range(0, 7)); d.rw = 1'($urandom_range(0, 1));
    end
    i_data_addr = d.addr; i_data_wdata = d.wdata; i_data_funct3 = d.f3; i_data_rw = d.rw;

    ack = 0;
    rd = $urandom;
    if (o_mem_req) begin
      if (mem_age == 0) cur_lat = pick_lat();
      if (cur_lat >= 0 && mem_age == cur_lat) begin
        ack = 1;
        if (!o_mem_rw) rd = memfn(o_mem_addr);
      end
      mem_age++;
    end else begin
      mem_age = 0;
      if (force_stray || (stray_en && $urandom_range(0, 3) == 0)) ack = 1;
    end
    force_stray = 0;
    i_mem_ack = ack;
    i_mem_rdata = rd;

    p_inst_req = i_inst_req; p_inst_addr = i_inst_addr;
    p_data_req = i_data_req; p_data_addr = i_data_addr; p_data_wdata = i_data_wdata;
    p_data_f3 = i_data_funct3; p_data_rw = i_data_rw;
    p_mem_ack = i_mem_ack; p_mem_rdata = i_mem_rdata;
  endtask

  task automatic clear_stats();
    inst_acks = 0; data_acks = 0; mem_hi = 0; pushes = 0;
    mem_log.delete();
  endtask

  task automatic drain(input string tag, input int max_cycles);
    int n;
    bit done;
    n = 0;
    done = 0;
    while (!done && n < max_cycles) begin
      step();
      n++;
      if (inst_q.size() == 0 && data_q.size() == 0 && m_ph == 0 && !o_mem_req) done = 1;
    end
    step();
    step();
    chk({tag, "_bound"}, done, 1);
  endtask

  task automatic idle_inputs();
    i_inst_req = 0; i_inst_addr = 0;
    i_data_req = 0; i_data_addr = 0; i_data_wdata = 0; i_data_funct3 = 0; i_data_rw = 0;
    i_mem_ack = 0; i_mem_rdata = 0;
  endtask

  initial begin
    dreq_t d;
    idle_inputs();
    inst_q.delete(); data_q.delete();
    gen_en = 0; stray_en = 0; force_stray = 0; lat_mode = 2;
    mem_age = 0; cur_lat = 0; seen_req = 0;
    clear_stats();
    model_reset();
    rst_n = 1;
    #1 rst_n = 0;
    #1 all_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1;

    // Fetch only, memory acks two cycles after request
    lat_mode = 2;
    clear_stats();
    inst_q.push_back(32'h0000_0010);
    drain("t1", 40);
    chk("t1_req_cycles", mem_hi, 3);
    chk("t1_inst_acks", inst_acks, 1);
    chk("t1_data_acks", data_acks, 0);

    // Simultaneous fetch and data read: data first
    lat_mode = -2;
    clear_stats();
    inst_q.push_back(32'h0000_0004);
    d = '{addr: 32'h100, wdata: 32'h0, f3: 3'b010, rw: 1'b0};
    data_q.push_back(d);
    drain("t2", 60);
    chk("t2_first_addr", mem_log.size() > 0 ? mem_log[0] : 32'hFFFF_FFFF, 32'h100);
    chk("t2_second_addr", mem_log.size() > 1 ? mem_log[1] : 32'hFFFF_FFFF, 32'h4);
    chk("t2_inst_acks", inst_acks, 1);
    chk("t2_data_acks", data_acks, 1);

    // Starvation guard: fetch gets every fifth grant
    clear_stats();
    for (int i = 0; i < 3; i++) inst_q.push_back(32'h40 + 32'(4 * i));
    for (int i = 0; i < 10; i++) begin
      d = '{addr: 32'h1000 + 32'(4 * i), wdata: $urandom, f3: 3'b010, rw: 1'($urandom_range(0, 1))};
      data_q.push_back(d);
    end
    drain("t3", 400);
    chk("t3_grant4", mem_log.size() > 4 ? mem_log[4] : 32'hFFFF_FFFF, 32'h40);
    chk("t3_grant9", mem_log.size() > 9 ? mem_log[9] : 32'hFFFF_FFFF, 32'h44);
    chk("t3_grant12", mem_log.size() > 12 ? mem_log[12] : 32'hFFFF_FFFF, 32'h48);

    // Store
    lat_mode = 1;
    clear_stats();
    d = '{addr: 32'h200, wdata: 32'hDEAD_BEEF, f3: 3'b000, rw: 1'b1};
    data_q.push_back(d);
    drain("t4", 40);
    chk("t4_data_acks", data_acks, 1);

    // Watchdog timeout, then a normal transaction, then ack in the final watchdog cycle
    lat_mode = -1;
    clear_stats();
    d = '{addr: 32'h300, wdata: 32'h0, f3: 3'b010, rw: 1'b0};
    data_q.push_back(d);
    drain("t5", 60);
    chk("t5_req_cycles", mem_hi, TMO);
    lat_mode = 3;
    d = '{addr: 32'h304, wdata: 32'h0, f3: 3'b010, rw: 1'b0};
    data_q.push_back(d);
    drain("t5b", 60);
    lat_mode = TMO - 1;
    inst_q.push_back(32'h308);
    drain("t5c", 60);
    chk("t5_data_acks", data_acks, 2);
    chk("t5_inst_acks", inst_acks, 1);

    // Reset during WAIT_ACK, then a late ack
    lat_mode = -1;
    d = '{addr: 32'h400, wdata: 32'h0, f3: 3'b010, rw: 1'b0};
    data_q.push_back(d);
    step(); step(); step();
    #2 rst_n = 0;
    #1 all_zero("t6_reset");
    inst_q.delete(); data_q.delete();
    idle_inputs();
    model_reset();
    mem_age = 0; seen_req = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1;
    clear_stats();
    force_stray = 1;
    for (int i = 0; i < 5; i++) step();
    chk("t6_inst_acks", inst_acks, 0);
    chk("t6_data_acks", data_acks, 0);
    chk("t6_mem_req", mem_hi, 0);

    // Randomized traffic with stray acks and occasional timeouts
    lat_mode = -2;
    stray_en = 1;
    clear_stats();
    gen_en = 1;
    for (int i = 0; i < 1500; i++) step();
    gen_en = 0;
    drain("rand", 200);
    chk("rand_acks", inst_acks + data_acks, pushes);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
